onfi_async_sequencer: RTL and testbench
=======================================

# onfi_async_sequencer

Cycle-accurate ONFI asynchronous (SDR) bus sequencer that sits directly upstream of `nand_controller` and drives its CE/CLE/ALE/WE/RE/WP pins and 8-bit DQ lane 0. It converts a stream of byte-level requests (command, address, data-in, data-out, wait-ready, write-protect) into correctly timed pin waveforms. It returns read bytes and ready/busy completion to the host side.

## Interface
Parameters:
- `TWP`, 2: WE_x_n low cycles per write-type byte (≥1)
- `TWH`, 2: WE_x_n high/hold cycles after each write-type byte (≥1)
- `TRP`, 2: RE_x_n low cycles per read byte (≥1)
- `TREH`, 2: RE_x_n high cycles after each read byte (≥1)
- `TWB`, 4: cycles ignored before R/B sampling in WAIT_RB (≥1)
- `TIMEOUT_CYC`, 65535: max WAIT_RB busy cycles before timeout (24-bit counter)
- `CE_IDLE`, 8: idle cycles before CE_x_n deasserts (≥1)

Ports:
- `clk`  in  1  sole clock; all logic rising-edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  sequencer can accept
- `req_op`  in  3  0=CMD, 1=ADDR, 2=DIN (write byte), 3=DOUT (read byte), 4=WAIT_RB, 5=SET_WP, 6-7=NOP
- `req_data`  in  8  byte for CMD/ADDR/DIN; bit0 = WP level for SET_WP
- `rsp_valid`  out  1  one-cycle pulse: DOUT byte or WAIT_RB done
- `rsp_data`  out  8  read byte (valid with rsp_valid after DOUT)
- `rsp_timeout`  out  1  valid with rsp_valid after WAIT_RB; 1 = timed out
- `CE_x_n`, `CLE_x`, `ALE_x`, `WE_x_n`, `RE_x_n`, `WP_x_n`  out  1 each  ONFI pins to `nand_controller`
- `dq_out`  out  8  DQ drive value; `dq_oe`  out  1  DQ output enable
- `dq_in`  in  8  DQ sampled value
- `RB_x_n`  in  1  ready/busy (asynchronous; 2-flop synchronised internally)

## Operation
- States: IDLE, WR_LO, WR_HI, RD_LO, RD_HI, WAIT_WB, WAIT_RB.
- `req_ready` = 1 only in IDLE and not in reset; transfer on `req_valid && req_ready`.
- CMD/ADDR/DIN: IDLE→WR_LO (TWP cycles: WE_x_n=0, dq_oe=1, dq_out=req_data, CLE_x=1 for CMD, ALE_x=1 for ADDR)→WR_HI (TWH cycles: WE_x_n=1, CLE/ALE/dq_out/dq_oe held)→IDLE, where CLE/ALE/dq_oe clear.
- DOUT: IDLE→RD_LO (TRP cycles, RE_x_n=0, dq_oe=0); `dq_in` captured on last RD_LO cycle→RD_HI (TREH cycles, RE_x_n=1); `rsp_valid`=1 with `rsp_data` on first RD_HI cycle.
- WAIT_RB: WAIT_WB for TWB cycles (R/B ignored)→WAIT_RB until synchronised R/B=1 (rsp_timeout=0) or busy count reaches TIMEOUT_CYC (rsp_timeout=1); rsp_valid pulses on the exit cycle→IDLE.
- SET_WP: WP_x_n ← req_data[0] on the cycle after acceptance; stays IDLE.
- NOP: consumed, no pin activity, no response.
- CE_x_n: 0 from the cycle after any non-NOP acceptance; returns to 1 after CE_IDLE consecutive IDLE cycles with no acceptance.

## Timing
- Reset values (cycle after `rst` sampled high, held while high): state IDLE, req_ready=0 during reset, CE_x_n=1, CLE_x=0, ALE_x=0, WE_x_n=1, RE_x_n=1, WP_x_n=0, dq_oe=0, dq_out=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, counters 0, sync flops 0.
- Write byte occupancy: TWP+TWH cycles; with defaults req_ready drops for 4 cycles, next accept 5 cycles after previous accept.
- Read occupancy: TRP+TREH; rsp_valid at accept+TRP+1.
- CLE/ALE/dq_out never change while WE_x_n=0; WE_x_n and RE_x_n never both 0.
- R/B latency: pin rise visible to FSM 2 cycles later.
- Reset mid-operation: pins return to reset values next edge, no rsp_valid emitted, pending op dropped.
- Timeout counter saturates; rsp_valid and RB-ready on same cycle as timeout ⇒ ready wins (rsp_timeout=0).

## Test plan
- Reset: assert rst 3 cycles mid WR_LO -> all outputs at reset values, no rsp_valid, req_ready=1 the cycle after release.
- CMD 0x00, ADDR 0x12, CMD 0x30 (defaults) -> each WE_x_n low exactly 2 cycles, CLE high only with 0x00/0x30, ALE only with 0x12, dq_out stable across each WE pulse; CE_x_n low throughout.
- WAIT_RB then DOUT: RB_x_n low 20 cycles after CMD 0x30 -> rsp_valid with rsp_timeout=0 ≥2 cycles after RB rise; DOUT with dq_in=0xA5 -> rsp_data=0xA5 at accept+3.
- WAIT_RB with RB_x_n stuck low, TIMEOUT_CYC=100 -> single rsp_valid, rsp_timeout=1, after 4+100 cycles.
- SET_WP 1 then DIN 0x5A -> WP_x_n=1 next cycle, dq_oe=1 for 4 cycles, dq_out=0x5A.
- Idle CE: after last op, no requests -> CE_x_n rises after exactly 8 IDLE cycles; NOP does not reassert it.

Source files
------------

// File: rtl/onfi_async_sequencer.sv
// ONFI asynchronous (SDR) pin sequencer: turns byte-level host requests
// into timed CE/CLE/ALE/WE/RE/WP/DQ waveforms and returns read data/R-B status.
module onfi_async_sequencer #(
   parameter int TWP         = 2,
   parameter int TWH         = 2,
   parameter int TRP         = 2,
   parameter int TREH        = 2,
   parameter int TWB         = 4,
   parameter int TIMEOUT_CYC = 65535,
   parameter int CE_IDLE     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic [2:0] req_op,
   input  logic [7:0] req_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_timeout,
   output logic       CE_x_n,
   output logic       CLE_x,
   output logic       ALE_x,
   output logic       WE_x_n,
   output logic       RE_x_n,
   output logic       WP_x_n,
   output logic [7:0] dq_out,
   output logic       dq_oe,
   input  logic [7:0] dq_in,
   input  logic       RB_x_n
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_WR_LO   = 3'd1,
      S_WR_HI   = 3'd2,
      S_RD_LO   = 3'd3,
      S_RD_HI   = 3'd4,
      S_WAIT_WB = 3'd5,
      S_WAIT_RB = 3'd6
   } state_t;

   localparam logic [23:0] LP_TWP  = 24'(TWP - 1);
   localparam logic [23:0] LP_TWH  = 24'(TWH - 1);
   localparam logic [23:0] LP_TRP  = 24'(TRP - 1);
   localparam logic [23:0] LP_TREH = 24'(TREH - 1);
   localparam logic [23:0] LP_TWB  = 24'(TWB - 1);
   localparam logic [23:0] LP_TO   = 24'(TIMEOUT_CYC - 1);
   localparam logic [23:0] LP_CE   = 24'(CE_IDLE - 1);
   localparam logic [23:0] LP_MAX  = 24'hFFFFFF;

   state_t      r_state;
   state_t      w_next;
   logic [23:0] r_cnt;
   logic [23:0] r_idle_cnt;
   logic        r_rb_meta;
   logic        r_rb_sync;
   logic        r_cle;
   logic        r_ale;
   logic [7:0]  r_dq;
   logic        r_wp;
   logic        r_ce_n;
   logic [7:0]  r_rdata;

   logic        w_ready;
   logic        w_accept;
   logic        w_op_wr;
   logic        w_op_rd;
   logic        w_op_wait;
   logic        w_op_wp;
   logic        w_op_nop;
   logic        w_to_hit;

   assign w_ready   = (r_state == S_IDLE) && !rst;
   assign w_accept  = req_valid && w_ready;
   assign w_op_wr   = (req_op == 3'd0) || (req_op == 3'd1) || (req_op == 3'd2);
   assign w_op_rd   = (req_op == 3'd3);
   assign w_op_wait = (req_op == 3'd4);
   assign w_op_wp   = (req_op == 3'd5);
   assign w_op_nop  = req_op[2] & req_op[1];
   // busy budget spent and the device still reports busy
   assign w_to_hit  = !r_rb_sync && (r_cnt >= LP_TO);

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // next-state decode
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_op_wr)        w_next = S_WR_LO;
               else if (w_op_rd)   w_next = S_RD_LO;
               else if (w_op_wait) w_next = S_WAIT_WB;
               else                w_next = S_IDLE;
            end
         end
         S_WR_LO:   if (r_cnt == LP_TWP)  w_next = S_WR_HI;
         S_WR_HI:   if (r_cnt == LP_TWH)  w_next = S_IDLE;
         S_RD_LO:   if (r_cnt == LP_TRP)  w_next = S_RD_HI;
         S_RD_HI:   if (r_cnt == LP_TREH) w_next = S_IDLE;
         S_WAIT_WB: if (r_cnt == LP_TWB)  w_next = S_WAIT_RB;
         S_WAIT_RB: if (r_rb_sync || w_to_hit) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // per-phase cycle counter; also the saturating busy counter in WAIT_RB
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if ((r_state != w_next) || (r_state == S_IDLE)) begin
         r_cnt <= '0;
      end else if (r_cnt != LP_MAX) begin
         r_cnt <= r_cnt + 24'd1;
      end
   end

   // two-flop synchroniser for the asynchronous ready/busy pin
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rb_meta <= 1'b0;
         r_rb_sync <= 1'b0;
      end else begin
         r_rb_meta <= RB_x_n;
         r_rb_sync <= r_rb_meta;
      end
   end

   // latch byte, latch-enable flags and WP level at request acceptance
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cle <= 1'b0;
         r_ale <= 1'b0;
         r_dq  <= '0;
         r_wp  <= 1'b0;
      end else if (w_accept) begin
         if (w_op_wr) begin
            r_cle <= (req_op == 3'd0);
            r_ale <= (req_op == 3'd1);
            r_dq  <= req_data;
         end
         if (w_op_wp) begin
            r_wp <= req_data[0];
         end
      end
   end

   // capture DQ on the final RE low cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
      end else if ((r_state == S_RD_LO) && (r_cnt == LP_TRP)) begin
         r_rdata <= dq_in;
      end
   end

   // chip enable: assert on real work, release after a run of idle cycles
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ce_n     <= 1'b1;
         r_idle_cnt <= '0;
      end else if (w_accept) begin
         r_idle_cnt <= '0;
         if (!w_op_nop) begin
            r_ce_n <= 1'b0;
         end
      end else if (r_state == S_IDLE) begin
         if (r_idle_cnt >= LP_CE) begin
            r_ce_n <= 1'b1;
         end
         if (r_idle_cnt != LP_MAX) begin
            r_idle_cnt <= r_idle_cnt + 24'd1;
         end
      end else begin
         r_idle_cnt <= '0;
      end
   end

   // pin and response decode from the current state
   always_comb begin
      req_ready   = w_ready;
      rsp_valid   = 1'b0;
      rsp_timeout = 1'b0;
      rsp_data    = r_rdata;
      CE_x_n      = r_ce_n;
      CLE_x       = 1'b0;
      ALE_x       = 1'b0;
      WE_x_n      = 1'b1;
      RE_x_n      = 1'b1;
      WP_x_n      = r_wp;
      dq_out      = r_dq;
      dq_oe       = 1'b0;
      case (r_state)
         S_WR_LO: begin
            WE_x_n = 1'b0;
            CLE_x  = r_cle;
            ALE_x  = r_ale;
            dq_oe  = 1'b1;
         end
         S_WR_HI: begin
            CLE_x = r_cle;
            ALE_x = r_ale;
            dq_oe = 1'b1;
         end
         S_RD_LO: begin
            RE_x_n = 1'b0;
         end
         S_RD_HI: begin
            rsp_valid = (r_cnt == 24'd0);
         end
         S_WAIT_RB: begin
            rsp_valid   = r_rb_sync || w_to_hit;
            rsp_timeout = w_to_hit;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_onfi_async_sequencer.sv
// Directed bench for onfi_async_sequencer: write/read/wait/WP/CE-idle
// waveforms checked cycle by cycle against hand-derived expectations.
module tb_onfi_async_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [2:0] req_op;
   logic [7:0] req_data;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_timeout;
   logic       CE_x_n;
   logic       CLE_x;
   logic       ALE_x;
   logic       WE_x_n;
   logic       RE_x_n;
   logic       WP_x_n;
   logic [7:0] dq_out;
   logic       dq_oe;
   logic [7:0] dq_in;
   logic       RB_x_n;

   int n_cmp = 0;
   int n_err = 0;
   int seen;

   always #5 clk = ~clk;

   onfi_async_sequencer #(
      .TWP(2), .TWH(2), .TRP(2), .TREH(2),
      .TWB(4), .TIMEOUT_CYC(100), .CE_IDLE(8)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .rsp_timeout(rsp_timeout),
      .CE_x_n(CE_x_n), .CLE_x(CLE_x), .ALE_x(ALE_x),
      .WE_x_n(WE_x_n), .RE_x_n(RE_x_n), .WP_x_n(WP_x_n),
      .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in),
      .RB_x_n(RB_x_n)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [7:0] d);
      chk1("ready_before_issue", req_ready, 1'b1);
      req_valid = 1'b1;
      req_op    = op;
      req_data  = d;
      @(negedge clk);
      req_valid = 1'b0;
      req_op    = 3'd6;
      req_data  = 8'h00;
   endtask

   task automatic wr_byte(input string tag, input logic [2:0] op,
                          input logic [7:0] d, input logic cle, input logic ale);
      issue(op, d);
      for (int c = 1; c <= 4; c++) begin
         chk1({tag, "_we"}, WE_x_n, (c > 2));
         chk1({tag, "_re"}, RE_x_n, 1'b1);
         chk1({tag, "_cle"}, CLE_x, cle);
         chk1({tag, "_ale"}, ALE_x, ale);
         chk1({tag, "_oe"}, dq_oe, 1'b1);
         chk8({tag, "_dq"}, dq_out, d);
         chk1({tag, "_ce"}, CE_x_n, 1'b0);
         chk1({tag, "_busy"}, req_ready, 1'b0);
         @(negedge clk);
      end
      chk1({tag, "_ready_end"}, req_ready, 1'b1);
      chk1({tag, "_we_end"}, WE_x_n, 1'b1);
      chk1({tag, "_cle_end"}, CLE_x, 1'b0);
      chk1({tag, "_ale_end"}, ALE_x, 1'b0);
      chk1({tag, "_oe_end"}, dq_oe, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_op    = 3'd6;
      req_data  = 8'h00;
      dq_in     = 8'h00;
      RB_x_n    = 1'b1;
      repeat (3) @(negedge clk);

      // reset values
      chk1("rst_ready", req_ready, 1'b0);
      chk1("rst_ce", CE_x_n, 1'b1);
      chk1("rst_we", WE_x_n, 1'b1);
      chk1("rst_re", RE_x_n, 1'b1);
      chk1("rst_wp", WP_x_n, 1'b0);
      chk1("rst_oe", dq_oe, 1'b0);
      chk8("rst_dq", dq_out, 8'h00);
      chk1("rst_rsp", rsp_valid, 1'b0);
      chk8("rst_rdata", rsp_data, 8'h00);
      rst = 1'b0;
      @(negedge clk);
      chk1("rel_ready", req_ready, 1'b1);

      // reset in the middle of WR_LO
      issue(3'd0, 8'hFF);
      chk1("mid_we_lo", WE_x_n, 1'b0);
      chk1("mid_cle", CLE_x, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      chk1("mid_rst_we", WE_x_n, 1'b1);
      chk1("mid_rst_cle", CLE_x, 1'b0);
      chk1("mid_rst_oe", dq_oe, 1'b0);
      chk1("mid_rst_ce", CE_x_n, 1'b1);
      chk1("mid_rst_ready", req_ready, 1'b0);
      chk1("mid_rst_rsp", rsp_valid, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk1("mid_rst_hold_we", WE_x_n, 1'b1);
      chk8("mid_rst_dq", dq_out, 8'h00);
      rst = 1'b0;
      @(negedge clk);
      chk1("mid_rel_ready", req_ready, 1'b1);
      chk1("mid_rel_ce", CE_x_n, 1'b1);
      chk1("mid_rel_rsp", rsp_valid, 1'b0);

      // command/address sequence
      wr_byte("cmd00", 3'd0, 8'h00, 1'b1, 1'b0);
      wr_byte("adr12", 3'd1, 8'h12, 1'b0, 1'b1);
      wr_byte("cmd30", 3'd0, 8'h30, 1'b1, 1'b0);

      // wait ready: busy for 20 cycles
      RB_x_n = 1'b0;
      issue(3'd4, 8'h00);
      seen = 0;
      for (int c = 1; c <= 21; c++) begin
         if (rsp_valid) seen++;
         if (c == 20) RB_x_n = 1'b1;
         @(negedge clk);
      end
      chk1("rb_no_early_rsp", (seen != 0), 1'b0);
      chk1("rb_rsp", rsp_valid, 1'b1);
      chk1("rb_not_to", rsp_timeout, 1'b0);
      @(negedge clk);
      chk1("rb_rsp_pulse", rsp_valid, 1'b0);
      chk1("rb_ready", req_ready, 1'b1);

      // read one byte
      dq_in = 8'hA5;
      issue(3'd3, 8'h00);
      chk1("rd_re_lo1", RE_x_n, 1'b0);
      chk1("rd_we", WE_x_n, 1'b1);
      chk1("rd_oe", dq_oe, 1'b0);
      chk1("rd_rsp1", rsp_valid, 1'b0);
      @(negedge clk);
      chk1("rd_re_lo2", RE_x_n, 1'b0);
      chk1("rd_rsp2", rsp_valid, 1'b0);
      @(negedge clk);
      chk1("rd_rsp3", rsp_valid, 1'b1);
      chk8("rd_data3", rsp_data, 8'hA5);
      chk1("rd_re_hi3", RE_x_n, 1'b1);
      dq_in = 8'h3C;
      @(negedge clk);
      chk1("rd_rsp4", rsp_valid, 1'b0);
      chk8("rd_data_hold", rsp_data, 8'hA5);
      chk1("rd_busy4", req_ready, 1'b0);
      @(negedge clk);
      chk1("rd_ready5", req_ready, 1'b1);

      // wait ready with R/B stuck busy: timeout
      RB_x_n = 1'b0;
      issue(3'd4, 8'h00);
      seen = 0;
      for (int c = 1; c <= 103; c++) begin
         if (rsp_valid) seen++;
         @(negedge clk);
      end
      chk1("to_no_early_rsp", (seen != 0), 1'b0);
      chk1("to_rsp", rsp_valid, 1'b1);
      chk1("to_flag", rsp_timeout, 1'b1);
      RB_x_n = 1'b1;
      @(negedge clk);
      chk1("to_rsp_pulse", rsp_valid, 1'b0);
      chk1("to_flag_clr", rsp_timeout, 1'b0);
      chk1("to_ready", req_ready, 1'b1);

      // write protect then data byte
      issue(3'd5, 8'h01);
      chk1("wp_level", WP_x_n, 1'b1);
      chk1("wp_we", WE_x_n, 1'b1);
      wr_byte("din5a", 3'd2, 8'h5A, 1'b0, 1'b0);
      chk1("wp_kept", WP_x_n, 1'b1);

      // CE release after 8 idle cycles; NOP leaves it released
      chk1("ce_idle1", CE_x_n, 1'b0);
      repeat (7) @(negedge clk);
      chk1("ce_idle8", CE_x_n, 1'b0);
      @(negedge clk);
      chk1("ce_released", CE_x_n, 1'b1);
      issue(3'd6, 8'h00);
      chk1("nop_ce", CE_x_n, 1'b1);
      chk1("nop_ready", req_ready, 1'b1);
      repeat (3) @(negedge clk);
      chk1("nop_ce_later", CE_x_n, 1'b1);
      chk1("nop_we", WE_x_n, 1'b1);
      chk1("nop_oe", dq_oe, 1'b0);
      chk1("nop_rsp", rsp_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
